// File: rtl/izz_pkg.sv
// Shared constants, input-FSM state type and index helpers for the izigzag sequencer.
package izz_pkg;

    localparam int DW   = 32;
    localparam int N    = 64;
    localparam int IDXW = 6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } in_state_e;

    function automatic logic is_last_idx(input logic [IDXW-1:0] idx);
        return idx == IDXW'(N - 1);
    endfunction

    function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] idx);
        return is_last_idx(idx) ? '0 : idx + IDXW'(1);
    endfunction

endpackage

// File: rtl/izz_out_stream.sv
// Output buffer for one reordered 8x8 block, drained one raster-order word per beat.
module izz_out_stream
    import izz_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DW*N-1:0]   cap_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              obuf_free,
    output logic              drain_done
);

    logic [DW-1:0]   obuf_q [N];
    logic [DW-1:0]   obuf_d [N];
    logic            out_valid_q;
    logic            out_valid_d;
    logic [IDXW-1:0] out_idx_q;
    logic [IDXW-1:0] out_idx_d;

    // Kept as a plain assign so it does not depend on capture.
    assign drain_done = out_valid_q & out_ready & is_last_idx(out_idx_q);

    always_comb begin
        obuf_d      = obuf_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                obuf_d[k] = cap_data[DW*k +: DW];
            end
            out_valid_d = 1'b1;
            out_idx_d   = '0;
        end else if (out_valid_q && out_ready) begin
            out_idx_d = idx_inc(out_idx_q);
            if (is_last_idx(out_idx_q)) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                obuf_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            obuf_q      <= obuf_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = obuf_q[out_idx_q];
    assign out_last  = is_last_idx(out_idx_q);
    assign obuf_free = ~out_valid_q;

endmodule

// File: rtl/izigzag_seq_ctrl.sv
// Sequencer around the izigzag datapath: packs 64 zig-zag words, captures the raster block, drains it.
// Define IZZ_CTRL_OVERLAP_EN to load the next block while the previous one drains.
module izigzag_seq_ctrl
    import izz_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic [DW*N-1:0]   zz_data,
    input  logic [DW*N-1:0]   dp_data,
    input  logic              dp_finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Both streams: a word moves on a rising edge where valid & ready are high; valid never
    // drops without a transfer, and payload holds while valid & !ready.

    localparam int WCW = $clog2(LAT + 2);

    in_state_e       state_q;
    in_state_e       state_d;
    logic [IDXW-1:0] wr_cnt_q;
    logic [IDXW-1:0] wr_cnt_d;
    logic [WCW-1:0]  wait_cnt_q;
    logic [WCW-1:0]  wait_cnt_d;
    logic            in_ready_q;
    logic            in_ready_d;
    logic [DW-1:0]   zz_q [N];
    logic [DW-1:0]   zz_d [N];

    logic            in_fire;
    logic            last_accept;
    logic            capture;
    logic            obuf_free;
    logic            drain_done;

    assign in_fire     = in_valid & in_ready_q;
    assign last_accept = in_fire & is_last_idx(wr_cnt_q);

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        in_ready_d = in_ready_q;
        zz_d       = zz_q;
        capture    = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    zz_d[wr_cnt_q] = in_data;
                    wr_cnt_d       = idx_inc(wr_cnt_q);
                end
                if (last_accept) begin
                    wait_cnt_d = WCW'(LAT);
                    state_d    = WAIT;
                    in_ready_d = 1'b0;
                end else begin
`ifdef IZZ_CTRL_OVERLAP_EN
                    in_ready_d = 1'b1;
`else
                    // Reopen only once the previous block has fully left the output buffer.
                    in_ready_d = obuf_free | drain_done;
`endif
                end
            end
            WAIT, FULL: begin
                in_ready_d = 1'b0;
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
                if ((wait_cnt_q == '0) && dp_finish && obuf_free) begin
                    capture = 1'b1;
                    state_d = LOAD;
`ifdef IZZ_CTRL_OVERLAP_EN
                    in_ready_d = 1'b1;
`else
                    in_ready_d = 1'b0;
`endif
                end else if ((state_q == WAIT) && (wait_cnt_q == '0) && !obuf_free) begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d    = LOAD;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // Reset parks the FSM in LOAD with in_ready low; the first edge afterwards opens the input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD;
            wr_cnt_q   <= '0;
            wait_cnt_q <= '0;
            in_ready_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                zz_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            in_ready_q <= in_ready_d;
            zz_q       <= zz_d;
        end
    end

    always_comb begin
        zz_data = '0;
        for (int k = 0; k < N; k++) begin
            zz_data[DW*k +: DW] = zz_q[k];
        end
    end

    izz_out_stream u_out (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .cap_data   (dp_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .obuf_free  (obuf_free),
        .drain_done (drain_done)
    );

    assign in_ready  = in_ready_q;
    assign busy      = (wr_cnt_q != '0) | (state_q != LOAD) | out_valid;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_izigzag_seq_ctrl.sv
// Directed-plus-random bench for izigzag_seq_ctrl with a behavioural zig-zag model and scoreboard.
module tb_izigzag_seq_ctrl;

    localparam int DW   = 32;
    localparam int N    = 64;
    localparam int IDXW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic [DW*N-1:0]   zz_data;
    logic [DW*N-1:0]   dp_data = '0;
    logic              dp_finish = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [IDXW-1:0]   out_idx;
    logic              out_last;
    logic              busy;
    logic [1:0]        dbg_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    int             zz2r [N];
    int             r2zz [N];
    logic [DW-1:0]  blk [N];
    logic [DW-1:0]  exp_q [$];
    logic [DW-1:0]  obs_log [N];
    int             beats = 0;
    int             exp_idx = 0;
    int             rdy_mode = 0;

    izigzag_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .zz_data   (zz_data),
        .dp_data   (dp_data),
        .dp_finish (dp_finish),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset helpers ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- izigzag stand-in: one register stage ----------------
    always @(posedge clk) begin
        logic [DW*N-1:0] tmp;
        tmp = '0;
        for (int k = 0; k < N; k++) begin
            tmp[DW*zz2r[k] +: DW] = zz_data[DW*k +: DW];
        end
        dp_data <= tmp;
    end

    // ---------------- out_ready pattern ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Zig-zag scan: walk anti-diagonals, alternating direction.
    task automatic build_tables();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin
                    zz2r[k] = row * 8 + (s - row);
                    k++;
                end
            end else begin
                for (int row = lo; row <= hi; row++) begin
                    zz2r[k] = row * 8 + (s - row);
                    k++;
                end
            end
        end
        for (int i = 0; i < N; i++) r2zz[zz2r[i]] = i;
    endtask

    // ---------------- scoreboard / monitor (negedge sampling) ----------------
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data;
    logic [IDXW-1:0] prev_idx;
    logic           last_hs = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            last_hs    = 1'b0;
            exp_idx    = 0;
        end else begin
`ifndef IZZ_CTRL_OVERLAP_EN
            if (out_valid) chk("no_load_during_drain", in_ready, 1'b0);
            if (last_hs) chk("ready_after_drain", in_ready, 1'b1);
`endif
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1'b1);
                chk("stall_data_held", out_data, prev_data);
                chk("stall_idx_held", out_idx, prev_idx);
            end
            if (out_valid && out_ready) begin
                chk("beat_has_expect", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
                chk("out_idx", out_idx, exp_idx);
                chk("out_last", out_last, exp_idx == N - 1);
                obs_log[exp_idx] = out_data;
                exp_idx = (exp_idx + 1) % N;
                beats++;
            end
            last_hs    = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send_words(input int n, input int max_gap, input bit push_exp);
        for (int k = 0; k < n; k++) begin
            bit acc;
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = blk[k];
            acc = 1'b0;
            for (int t = 0; t < 1000 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            chk("in_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
        if (push_exp) begin
            for (int r = 0; r < N; r++) exp_q.push_back(blk[r2zz[r]]);
        end
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 400 && !out_valid; t++) @(negedge clk);
        chk("wait_valid", out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
        chk("drain_q_empty", exp_q.size(), 0);
        chk("drain_valid_low", out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_zz_zero"}, |zz_data, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic rand_blk(input int base);
        for (int k = 0; k < N; k++) blk[k] = (base < 0) ? $urandom() : DW'(base + k);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW*N-1:0] zz_saved;
        logic [DW-1:0]   first_raster [10];
        first_raster = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd14, 32'd15, 32'd27, 32'd28, 32'd2, 32'd4};
        build_tables();
        rdy_mode = 0;

        // Reset values, then the first edge after release opens the input.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        rst = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", in_ready, 1'b1);

        // 1: words k, no backpressure; out_valid two cycles after last accept.
        rand_blk(0);
        beats = 0;
        send_words(N, 0, 1'b1);
        @(negedge clk);
        chk("t1_valid_lat0", out_valid, 1'b0);
        chk("t1_ready_low", in_ready, 1'b0);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk("t1_valid_lat1", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_lat2", out_valid, 1'b1);
        chk("t1_first_idx", out_idx, 0);
        wait_drain();
        for (int i = 0; i < 10; i++) chk("t1_raster_const", obs_log[i], first_raster[i]);
        chk("t1_beats", beats, N);
        chk("t1_idle_busy", busy, 1'b0);

        // 2: toggled out_ready, random data and input gaps.
        rdy_mode = 1;
        rand_blk(-1);
        beats = 0;
        send_words(N, 2, 1'b1);
        wait_drain();
        chk("t2_beats", beats, N);

        // 3: dp_finish low for 5 cycles after load.
        rdy_mode = 0;
        rand_blk(-1);
        beats = 0;
        dp_finish = 1'b0;
        send_words(N, 0, 1'b1);
        zz_saved = zz_data;
        repeat (5) begin
            @(negedge clk);
            chk("t3_no_capture", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("t3_zz_held", zz_data === zz_saved, 1'b1);
        dp_finish = 1'b1;
        @(negedge clk);
        chk("t3_before_capture", out_valid, 1'b0);
        @(negedge clk);
        chk("t3_capture", out_valid, 1'b1);
        @(posedge clk);
        #1;
        wait_drain();
        chk("t3_beats", beats, N);

        // 4: two blocks back-to-back.
        rand_blk(0);
        beats = 0;
        send_words(N, 0, 1'b1);
        wait_valid();
`ifdef IZZ_CTRL_OVERLAP_EN
        chk("t4_ready_during_drain", in_ready, 1'b1);
`else
        chk("t4_ready_during_drain", in_ready, 1'b0);
`endif
        @(posedge clk);
        #1;
        rand_blk(100);
        send_words(N, 0, 1'b1);
        wait_drain();
        chk("t4_beats", beats, 2 * N);

`ifdef IZZ_CTRL_OVERLAP_EN
        // 5: output stalled; block 1 completes and must wait without disturbing block 0.
        rdy_mode = 2;
        rand_blk(-1);
        beats = 0;
        send_words(N, 0, 1'b1);
        wait_valid();
        @(posedge clk);
        #1;
        rand_blk(-1);
        send_words(N, 1, 1'b1);
        zz_saved = zz_data;
        repeat (200) begin
            @(negedge clk);
            chk("t5_ready_low", in_ready, 1'b0);
            chk("t5_idx_stuck", out_idx, 0);
        end
        chk("t5_zz_held", zz_data === zz_saved, 1'b1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain();
        chk("t5_beats", beats, 2 * N);
`endif

        // 6: reset in the middle of a load discards the partial block.
        rdy_mode = 3;
        rand_blk(-1);
        send_words(30, 1, 1'b0);
        @(negedge clk);
        chk("t6_busy_partial", busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_values("t6_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ready_first_edge", in_ready, 1'b1);
        rand_blk(-1);
        beats = 0;
        send_words(N, 1, 1'b1);
        wait_drain();
        chk("t6_beats", beats, N);
        chk("t6_idle_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
